alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle front end that drives the control side of the datapath ALU. It accepts one ARM data-processing command per handshake and decodes the opcode into the 4-bit ALU control code. When operand 2 carries a nonzero shift, it runs the shared ALU twice: first the shift pass, then the data pass. It returns the result, a register-write enable and N/Z flags over a valid/ready response port.

## Interface
- N, default 32: datapath width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  sequencer can accept a command; high only in IDLE.
- req_opcode  in  4  ARM data-processing opcode.
- req_rn  in  N  operand 1.
- req_op2  in  N  operand 2 before the shift.
- req_shtype  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 no shift.
- req_shamt  in  5  shift amount.
- req_s  in  1  set-flags request.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_ctrl  out  4  ALU control code.
- alu_y  in  N  combinational ALU result for the current alu_a/alu_b/alu_ctrl.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  N  final result.
- rsp_write  out  1  destination register is written.
- rsp_flags  out  2  {N,Z}.
- rsp_illegal  out  1  opcode is unsupported.

## Operation
- ALU control codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 slr, 0111 sar.
- Opcode decode (opcode → ctrl, operands, rsp_write):
  - AND → 0010, write 1.
  - EOR → 0100, write 1.
  - SUB → 0001, write 1.
  - RSB → 0001 with A/B swapped, write 1.
  - ADD → 0000, write 1.
  - TST → 0010, write 0.
  - TEQ → 0100, write 0.
  - CMP → 0001, write 0.
  - CMN → 0000, write 0.
  - ORR → 0011, write 1.
  - MOV → 0011 with A=0, write 1.
- ADC, SBC, RSC, BIC, MVN are illegal: no ALU pass, rsp_illegal=1, rsp_result=0, rsp_write=0, rsp_flags=00.
- A command is accepted when req_valid && req_ready. All request fields are latched on acceptance.
- FSM states:
  - IDLE: on accept, go to DONE if illegal. Otherwise go to SHIFT if shtype≠11 and shamt≠0. Otherwise go to EXEC.
  - SHIFT: alu_a=op2 reg, alu_b=zero-extended shamt, alu_ctrl=0101/0110/0111 for LSL/LSR/ASR. alu_y is written back into the op2 reg. Next state EXEC.
  - EXEC: drive the decoded ctrl and operands. Latch alu_y into the result reg. Latch flags: N=alu_y[N-1], Z=(alu_y==0). Next state DONE.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- Flags are reported when req_s=1 or the opcode is TST/TEQ/CMP/CMN; otherwise rsp_flags=00.
- In IDLE and DONE: alu_a=0, alu_b=0, alu_ctrl=0000.

## Timing
- Reset (asynchronous, any state) forces IDLE. All registered outputs clear: rsp_valid=0, rsp_result=0, rsp_write=0, rsp_flags=00, rsp_illegal=0. req_ready=1 after reset.
- Accept in cycle T:
  - No shift: rsp_valid from T+2.
  - With shift: rsp_valid from T+3.
  - Illegal: rsp_valid from T+1.
- Response outputs hold stable while rsp_valid && !rsp_ready.
- req_ready=0 from the accept edge until the response handshake completes. There is no overlap between commands, so a request and a response never complete in the same cycle.
- Back-to-back throughput is 1 command per 3 cycles (no shift, rsp_ready held high).
- shamt=0 with shtype≠11 skips the SHIFT state and uses op2 unchanged.

## Configuration
- ALU_OP_SEQUENCER_FLAGS_EN defined: N/Z flag registers and the flag-report logic are built as described.
- Not defined: the flag registers are removed and rsp_flags is tied to 00. All other behaviour and latency are unchanged.

## Structure
- alu_seq_pkg holds:
  - localparams for the ALU control codes.
  - enum for the ARM opcodes.
  - enum for the FSM states (IDLE, SHIFT, EXEC, DONE).
  - localparam for the shift-type encodings.
- Sub-module alu_seq_decode is purely combinational. It maps opcode to {ctrl, swap, zero_a, write, force_flags, illegal} and is instantiated once on the latched opcode.

## Test plan
- ADD, rn=5, op2=3, shtype=11 → rsp_valid at T+2, result 8, write 1, flags 00 (req_s=0).
- SUB with shift: rn=100, op2=5, LSL, shamt=2 → SHIFT pass shows alu_ctrl=0101, alu_b=2. Result 80 at T+3.
- RSB, rn=3, op2=10, req_s=1 → result 7, flags 00. Then CMP, rn=7, op2=7 → result 0, write 0, flags 01.
- ASR shift: op2=0x8000_0000, ASR, shamt=4, MOV → result 0xF800_0000. With flags enabled, req_s=1 gives flags 10.
- ADC opcode (0101) → rsp_valid at T+1, illegal 1, result 0, write 0.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles → response stable and req_ready=0 throughout.
  - Assert rst_n=0 during SHIFT → next sample shows IDLE, req_ready=1, rsp_valid=0, all response outputs 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU control codes, ARM opcode and FSM enums, shift-type encodings.
package alu_seq_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SLR = 4'b0110;
    localparam logic [3:0] ALU_SAR = 4'b0111;

    localparam logic [1:0] SH_LSL  = 2'b00;
    localparam logic [1:0] SH_LSR  = 2'b01;
    localparam logic [1:0] SH_ASR  = 2'b10;
    localparam logic [1:0] SH_NONE = 2'b11;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, DONE} state_e;

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {OP_ADC, OP_SBC, OP_RSC, OP_BIC, OP_MVN};
    endfunction
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational ARM opcode to ALU control/operand-steering decode.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] ctrl,
    output logic       swap,
    output logic       zero_a,
    output logic       write,
    output logic       force_flags,
    output logic       illegal
);
    always_comb begin
        ctrl = ALU_ADD;
        swap = 1'b0;
        zero_a = 1'b0;
        write = 1'b0;
        force_flags = 1'b0;
        illegal = is_illegal(opcode);
        case (opcode_e'(opcode))
            OP_AND: begin ctrl = ALU_AND; write = 1'b1; end
            OP_EOR: begin ctrl = ALU_XOR; write = 1'b1; end
            OP_SUB: begin ctrl = ALU_SUB; write = 1'b1; end
            OP_RSB: begin ctrl = ALU_SUB; write = 1'b1; swap = 1'b1; end
            OP_ADD: begin ctrl = ALU_ADD; write = 1'b1; end
            OP_TST: begin ctrl = ALU_AND; force_flags = 1'b1; end
            OP_TEQ: begin ctrl = ALU_XOR; force_flags = 1'b1; end
            OP_CMP: begin ctrl = ALU_SUB; force_flags = 1'b1; end
            OP_CMN: begin ctrl = ALU_ADD; force_flags = 1'b1; end
            OP_ORR: begin ctrl = ALU_OR; write = 1'b1; end
            OP_MOV: begin ctrl = ALU_OR; write = 1'b1; zero_a = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle ARM data-processing front end for a shared ALU (optional N/Z flags: ALU_OP_SEQUENCER_FLAGS_EN).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_opcode,
    input  logic [N-1:0] req_rn,
    input  logic [N-1:0] req_op2,
    input  logic [1:0]   req_shtype,
    input  logic [4:0]   req_shamt,
    input  logic         req_s,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_write,
    output logic [1:0]   rsp_flags,
    output logic         rsp_illegal
);
    state_e       state;
    logic [3:0]   opcode_q;
    logic [N-1:0] rn_q, op2_q;
    logic [1:0]   shtype_q;
    logic [4:0]   shamt_q;
    logic [3:0]   d_ctrl, shift_ctrl;
    logic         d_swap, d_zero_a, d_write, d_force_flags, d_illegal;
    logic [N-1:0] op_a, op_b;

    alu_seq_decode u_decode (
        .opcode      (opcode_q),
        .ctrl        (d_ctrl),
        .swap        (d_swap),
        .zero_a      (d_zero_a),
        .write       (d_write),
        .force_flags (d_force_flags),
        .illegal     (d_illegal)
    );

    assign op_a = d_zero_a ? '0 : d_swap ? op2_q : rn_q;
    assign op_b = d_swap ? rn_q : op2_q;
    assign shift_ctrl = shtype_q == SH_LSL ? ALU_SLL : shtype_q == SH_LSR ? ALU_SLR : ALU_SAR;

    always_comb begin
        alu_a = state == SHIFT ? op2_q : state == EXEC ? op_a : '0;
        alu_b = state == SHIFT ? {{(N-5){1'b0}}, shamt_q} : state == EXEC ? op_b : '0;
        alu_ctrl = state == SHIFT ? shift_ctrl : state == EXEC ? d_ctrl : ALU_ADD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_result <= '0;
            rsp_write <= 1'b0;
            rsp_illegal <= 1'b0;
            opcode_q <= '0;
            rn_q <= '0;
            op2_q <= '0;
            shtype_q <= SH_NONE;
            shamt_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    opcode_q <= req_opcode;
                    rn_q <= req_rn;
                    op2_q <= req_op2;
                    shtype_q <= req_shtype;
                    shamt_q <= req_shamt;
                    req_ready <= 1'b0;
                    if (is_illegal(req_opcode)) begin
                        state <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_illegal <= 1'b1;
                    end else begin
                        state <= (req_shtype != SH_NONE && req_shamt != 5'd0) ? SHIFT : EXEC;
                    end
                end
                SHIFT: begin
                    op2_q <= alu_y;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_y;
                    rsp_write <= d_write;
                    rsp_illegal <= d_illegal;
                    rsp_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (rsp_ready) begin
                    state <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_result <= '0;
                    rsp_write <= 1'b0;
                    rsp_illegal <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    logic       s_q;
    logic [1:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            flags_q <= 2'b00;
        end else if (state == IDLE && req_valid && req_ready) begin
            s_q <= req_s;
        end else if (state == EXEC) begin
            flags_q <= (s_q || d_force_flags) ? {alu_y[N-1], alu_y == '0} : 2'b00;
        end else if (state == DONE && rsp_ready) begin
            flags_q <= 2'b00;
        end
    end

    assign rsp_flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{req_s, d_force_flags};
    assign rsp_flags = 2'b00;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with a behavioural ARM reference model.
module tb_alu_op_sequencer;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_s = 1'b0;
    logic [3:0] req_opcode = '0;
    logic [31:0] req_rn = '0, req_op2 = '0;
    logic [1:0] req_shtype = 2'b11;
    logic [4:0] req_shamt = '0;
    logic [31:0] alu_a, alu_b, alu_y, rsp_result;
    logic [3:0] alu_ctrl;
    logic rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_illegal;
    logic [1:0] rsp_flags;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_rn(req_rn), .req_op2(req_op2),
        .req_shtype(req_shtype), .req_shamt(req_shamt), .req_s(req_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_write(rsp_write), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal)
    );

    // Datapath ALU the sequencer drives.
    always_comb begin
        case (alu_ctrl)
            4'd0: alu_y = alu_a + alu_b;
            4'd1: alu_y = alu_a - alu_b;
            4'd2: alu_y = alu_a & alu_b;
            4'd3: alu_y = alu_a | alu_b;
            4'd4: alu_y = alu_a ^ alu_b;
            4'd5: alu_y = alu_a << alu_b[4:0];
            4'd6: alu_y = alu_a >> alu_b[4:0];
            4'd7: alu_y = $signed(alu_a) >>> alu_b[4:0];
            default: alu_y = '0;
        endcase
    end

    function automatic void model(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                                  input logic [1:0] sht, input logic [4:0] sa, input logic s,
                                  output logic [31:0] res, output logic wr, output logic [1:0] fl,
                                  output logic ill, output int lat);
        logic [31:0] b;
        logic cmp;
        b = sht == 2'd0 ? op2 << sa : sht == 2'd1 ? op2 >> sa : sht == 2'd2 ? 32'($signed(op2) >>> sa) : op2;
        ill = op inside {4'h5, 4'h6, 4'h7, 4'hE, 4'hF};
        wr = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD};
        cmp = op inside {4'h8, 4'h9, 4'hA, 4'hB};
        case (op)
            4'h0, 4'h8: res = rn & b;
            4'h1, 4'h9: res = rn ^ b;
            4'h2, 4'hA: res = rn - b;
            4'h3:       res = b - rn;
            4'h4, 4'hB: res = rn + b;
            4'hC:       res = rn | b;
            4'hD:       res = b;
            default:    res = '0;
        endcase
        fl = (FLAGS_EN && !ill && (s || cmp)) ? {res[31], res == 32'd0} : 2'b00;
        lat = ill ? 1 : (sht != 2'd3 && sa != 5'd0) ? 3 : 2;
    endfunction

    // Issues one command from an idle point and waits (bounded) for rsp_valid.
    task automatic send(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                        input logic [1:0] sht, input logic [4:0] sa, input logic s,
                        output int lat, output logic [3:0] c0, output logic [31:0] b0);
        req_valid = 1'b1; req_opcode = op; req_rn = rn; req_op2 = op2;
        req_shtype = sht; req_shamt = sa; req_s = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_rn = $urandom; req_op2 = $urandom;
        c0 = alu_ctrl; b0 = alu_b; lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks += 6;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
        if (rsp_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", rsp_write); end
        if (rsp_flags !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", rsp_flags); end
        if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", rsp_illegal); end
    endtask

    task automatic test_add();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'h4, 32'd5, 32'd3, 2'b11, 5'd0, 1'b0, lat, c0, b0);
        checks += 6;
        if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
        if (rsp_result !== 32'd8) begin errors++; $display("FAIL add_result got=%0d exp=8", rsp_result); end
        if (rsp_write !== 1'b1) begin errors++; $display("FAIL add_write got=%b exp=1", rsp_write); end
        if (rsp_flags !== 2'b00) begin errors++; $display("FAIL add_flags got=%b exp=00", rsp_flags); end
        if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got=%b exp=0", rsp_illegal); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL add_req_ready got=%b exp=0", req_ready); end
        handshake();
    endtask

    task automatic test_shift();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'h2, 32'd100, 32'd5, 2'b00, 5'd2, 1'b0, lat, c0, b0);
        checks += 4;
        if (c0 !== 4'b0101) begin errors++; $display("FAIL shift_ctrl got=%b exp=0101", c0); end
        if (b0 !== 32'd2) begin errors++; $display("FAIL shift_b got=%0d exp=2", b0); end
        if (lat !== 3) begin errors++; $display("FAIL shift_latency got=%0d exp=3", lat); end
        if (rsp_result !== 32'd80) begin errors++; $display("FAIL shift_result got=%0d exp=80", rsp_result); end
        handshake();
    endtask

    task automatic test_rsb_cmp();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'h3, 32'd3, 32'd10, 2'b11, 5'd0, 1'b1, lat, c0, b0);
        checks += 2;
        if (rsp_result !== 32'd7) begin errors++; $display("FAIL rsb_result got=%0d exp=7", rsp_result); end
        if (rsp_flags !== 2'b00) begin errors++; $display("FAIL rsb_flags got=%b exp=00", rsp_flags); end
        handshake();
        send(4'hA, 32'd7, 32'd7, 2'b11, 5'd0, 1'b0, lat, c0, b0);
        checks += 3;
        if (rsp_result !== 32'd0) begin errors++; $display("FAIL cmp_result got=%0d exp=0", rsp_result); end
        if (rsp_write !== 1'b0) begin errors++; $display("FAIL cmp_write got=%b exp=0", rsp_write); end
        if (rsp_flags !== (FLAGS_EN ? 2'b01 : 2'b00)) begin errors++; $display("FAIL cmp_flags got=%b exp=%b", rsp_flags, FLAGS_EN ? 2'b01 : 2'b00); end
        handshake();
    endtask

    task automatic test_asr_mov();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'hD, 32'h1234_5678, 32'h8000_0000, 2'b10, 5'd4, 1'b1, lat, c0, b0);
        checks += 4;
        if (c0 !== 4'b0111) begin errors++; $display("FAIL asr_ctrl got=%b exp=0111", c0); end
        if (lat !== 3) begin errors++; $display("FAIL asr_latency got=%0d exp=3", lat); end
        if (rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL asr_result got=%h exp=f8000000", rsp_result); end
        if (rsp_flags !== (FLAGS_EN ? 2'b10 : 2'b00)) begin errors++; $display("FAIL asr_flags got=%b exp=%b", rsp_flags, FLAGS_EN ? 2'b10 : 2'b00); end
        handshake();
    endtask

    task automatic test_illegal();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'h5, 32'd9, 32'd9, 2'b00, 5'd3, 1'b1, lat, c0, b0);
        checks += 5;
        if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        if (rsp_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", rsp_illegal); end
        if (rsp_result !== 32'd0) begin errors++; $display("FAIL illegal_result got=%h exp=0", rsp_result); end
        if (rsp_write !== 1'b0) begin errors++; $display("FAIL illegal_write got=%b exp=0", rsp_write); end
        if (rsp_flags !== 2'b00) begin errors++; $display("FAIL illegal_flags got=%b exp=00", rsp_flags); end
        handshake();
    endtask

    task automatic test_shamt_zero();
        int lat; logic [3:0] c0; logic [31:0] b0;
        send(4'h4, 32'd20, 32'd22, 2'b00, 5'd0, 1'b0, lat, c0, b0);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL shamt0_latency got=%0d exp=2", lat); end
        if (rsp_result !== 32'd42) begin errors++; $display("FAIL shamt0_result got=%0d exp=42", rsp_result); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat; logic [3:0] c0; logic [31:0] b0;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        send(4'h1, a, b, 2'b11, 5'd0, 1'b0, lat, c0, b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks += 3;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
            if (rsp_result !== (a ^ b)) begin errors++; $display("FAIL bp_result[%0d] got=%h exp=%h", i, rsp_result, a ^ b); end
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
        end
        handshake();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid_shift();
        req_valid = 1'b1; req_opcode = 4'h4; req_rn = 32'd1; req_op2 = 32'd1;
        req_shtype = 2'b01; req_shamt = 5'd3; req_s = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (alu_ctrl !== 4'b0110) begin errors++; $display("FAIL midrst_in_shift got=%b exp=0110", alu_ctrl); end
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", rsp_valid); end
        if (rsp_result !== 32'd0) begin errors++; $display("FAIL midrst_result got=%h exp=0", rsp_result); end
        if (rsp_write !== 1'b0) begin errors++; $display("FAIL midrst_write got=%b exp=0", rsp_write); end
        if (rsp_flags !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b exp=00", rsp_flags); end
        if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL midrst_illegal got=%b exp=0", rsp_illegal); end
        if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL midrst_alu_ctrl got=%b exp=0000", alu_ctrl); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_after_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, resp = 0;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        req_valid = 1'b1; req_opcode = 4'h4; req_rn = a; req_op2 = b; req_shtype = 2'b11; req_shamt = 5'd0; req_s = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) acc++;
            @(posedge clk); #1;
            if (rsp_valid) begin
                resp++;
                checks++;
                if (rsp_result !== a + b) begin errors++; $display("FAIL b2b_result got=%h exp=%h", rsp_result, a + b); end
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks += 3;
        if (acc !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        if (resp !== 3) begin errors++; $display("FAIL b2b_responses got=%0d exp=3", resp); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_random();
        int lat, elat; logic [3:0] c0; logic [31:0] b0;
        logic [3:0] op; logic [31:0] rn, op2, eres; logic [1:0] sht, efl; logic [4:0] sa; logic s, ewr, eill;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom); rn = $urandom; op2 = $urandom;
            sht = 2'($urandom); sa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom); s = 1'($urandom);
            if ($urandom_range(0, 3) == 0) op2 = 32'h8000_0000 | op2;
            if ($urandom_range(0, 5) == 0) rn = op2;
            model(op, rn, op2, sht, sa, s, eres, ewr, efl, eill, elat);
            send(op, rn, op2, sht, sa, s, lat, c0, b0);
            checks += 5;
            if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency op=%h got=%0d exp=%0d", n, op, lat, elat); end
            if (rsp_result !== eres) begin errors++; $display("FAIL rnd%0d_result op=%h got=%h exp=%h", n, op, rsp_result, eres); end
            if (rsp_write !== ewr) begin errors++; $display("FAIL rnd%0d_write op=%h got=%b exp=%b", n, op, rsp_write, ewr); end
            if (rsp_flags !== efl) begin errors++; $display("FAIL rnd%0d_flags op=%h got=%b exp=%b", n, op, rsp_flags, efl); end
            if (rsp_illegal !== eill) begin errors++; $display("FAIL rnd%0d_illegal op=%h got=%b exp=%b", n, op, rsp_illegal, eill); end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            handshake();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_shift();
        test_rsb_cmp();
        test_asr_mov();
        test_illegal();
        test_shamt_zero();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
